seq_gen: RTL and testbench
==========================

# seq_gen

Serial pattern transmitter: on a start request, emits a WIDTH-bit pattern LSB-first, one bit per clock, optionally repeated with programmable idle gaps. It is the transmit end of the team's serial sequence-detection path. Its out pin drives a detector's serial input directly, and that detector matches the same pattern constant. A start/busy/done handshake lets a controller or testbench trigger frames.

## Interface
- WIDTH, 16, pattern length in bits (≥2)
- SEQ, 16'hABCD, pattern transmitted (bit 0 first)
- GAP_W, 4, width of the gap-length input
- REP_W, 4, width of the repeat-count input
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame request, sampled only in IDLE
- abort  in  1  synchronous abort, highest priority after reset
- rep_cnt  in  REP_W  extra repetitions after the first frame (0 = one frame)
- gap  in  GAP_W  idle cycles between repetitions (0 = back-to-back)
- out  out  1  serial data; 0 when not sending a bit
- valid  out  1  out carries a pattern bit
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse on normal completion
- load  in  1  (SEQ_GEN_LOAD_EN only) load pat_in as pattern
- pat_in  in  WIDTH  (SEQ_GEN_LOAD_EN only) runtime pattern

## Operation
- States: IDLE, SEND, GAP.
- IDLE, start=1: latch rep_cnt, gap, and the pattern into the shift register; bit counter = 0. Go to SEND.
- SEND: out = shreg[0], valid=1; shift right each cycle; bit counter increments.
  - After bit WIDTH-1 with no repeats left: go to IDLE and pulse done.
  - With repeats left and latched gap>0: go to GAP and decrement the repeat counter.
  - With repeats left and gap=0: reload the pattern and stay in SEND. Bit 0 of the next frame follows bit WIDTH-1 directly.
- GAP: out=0, valid=0 for exactly gap cycles. Then reload the pattern and enter SEND.
- start while busy: ignored, not queued. rep_cnt/gap changes while busy: no effect.
- abort=1 in any state: return to IDLE next cycle with out=0, valid=0, busy=0. done is not pulsed. In IDLE, abort overrides start.
- Counters: bit counter $clog2(WIDTH) bits, repeat counter REP_W, gap counter GAP_W. No wrap. Frames sent = rep_cnt+1, maximum 2^REP_W.

## Timing
- All outputs are registered. Reset values: out=0, valid=0, busy=0, done=0, state=IDLE, shift register = SEQ.
- start sampled at edge N: at N+1, busy=1, valid=1, out=SEQ[0]. Bit k appears at N+1+k.
- Single frame: last bit at N+WIDTH. At N+WIDTH+1, busy=0, valid=0, done=1 for one cycle.
- Total busy cycles = (rep_cnt+1)·WIDTH + rep_cnt·gap.
- A new start may be sampled in the same cycle done=1 (FSM already in IDLE).
- Reset asserted mid-frame: all outputs cleared immediately (asynchronously). The frame is lost.

## Configuration
- SEQ_GEN_LOAD_EN defined:
  - load and pat_in ports exist. A pattern register, reset to SEQ, is written from pat_in when load=1 in IDLE. load while busy is ignored.
  - Every frame, including repeats, uses the pattern register value latched at start.
- SEQ_GEN_LOAD_EN undefined: the load and pat_in ports are absent and the pattern is the constant SEQ.

## Structure
- Package seq_pkg holds:
  - the state typedef (enum IDLE/SEND/GAP);
  - the default pattern constant SEQ_DEFAULT = 16'hABCD and SEQ_W = 16, shared with the detector so the two cannot diverge.
- One sub-module, seq_piso: WIDTH-bit parallel-load, right-shift register with load/shift enables and a bit-0 output. seq_gen holds the FSM and counters.

## Test plan
- Reset, then start with rep_cnt=0, gap=0: out sequence LSB-first is 1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1 (0xABCD). valid is high for 16 cycles, then done pulses once. The detector in loopback asserts exactly once, the cycle after bit 15.
- rep_cnt=2, gap=3: three frames separated by exactly 3 cycles of out=0/valid=0. busy lasts 54 cycles. done pulses once at the end.
- rep_cnt=1, gap=0: 32 consecutive valid cycles with no bubble. The loopback detector fires twice, 16 cycles apart.
- start pulsed at bit 5 of an active frame: ignored, frame count unchanged. abort at bit 9: next cycle idle, busy=0, no done pulse.
- Reset asserted during GAP: outputs clear asynchronously. After release, a fresh start sends a full frame correctly.
- With SEQ_GEN_LOAD_EN: load pat_in=16'h1234, then start. out emits 0x1234 LSB-first. A load issued during that frame does not alter the bits already in flight.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path (transmitter and detector).
// Holds the FSM state type and the default pattern constant, so both ends
// of the loopback always agree on the pattern.
package seq_pkg;

  // Default pattern length and value, shared with the detector
  localparam int          SEQ_W       = 16;
  localparam logic [15:0] SEQ_DEFAULT = 16'hABCD;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

endpackage : seq_pkg

// File: rtl/seq_piso.sv
// Parallel-in / serial-out right-shift register.
// load_en has priority over shift_en; bit0_o is the LSB of the register.
module seq_piso
  import seq_pkg::*;
#(
  parameter int               WIDTH   = SEQ_W,
  parameter logic [WIDTH-1:0] RST_VAL = SEQ_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             bit0_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Next register value: parallel load, right shift with zero fill, or hold
  always_comb begin
    shreg_d = shreg_q;
    if (load_en) begin
      shreg_d = par_in;
    end else if (shift_en) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shift register state, asynchronously reset to the default pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= RST_VAL;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bit0_o = shreg_q[0];

endmodule : seq_piso

// File: rtl/seq_gen.sv
// Serial pattern transmitter: on start, sends a WIDTH-bit pattern LSB-first,
// optionally repeated rep_cnt extra times with gap idle cycles in between.
// Optional feature macro: SEQ_GEN_LOAD_EN adds load/pat_in for a runtime
// pattern register; without it the pattern is the constant SEQ.
//
// The first bit of each frame goes straight from the pattern into the out
// flop; the shift register is loaded with the remaining bits (pattern >> 1),
// so its bit 0 is always the next bit to be sent.
module seq_gen
  import seq_pkg::*;
#(
  parameter int               WIDTH = SEQ_W,
  parameter logic [WIDTH-1:0] SEQ   = SEQ_DEFAULT,
  parameter int               GAP_W = 4,
  parameter int               REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
`ifdef SEQ_GEN_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] pat_in,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  seq_state_e       state_q,   state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q,     rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             out_q,     out_d;
  logic             valid_q,   valid_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic             piso_load_s;
  logic             piso_shift_s;
  logic             piso_bit0_s;
  logic [WIDTH-1:0] pattern_s;

`ifdef SEQ_GEN_LOAD_EN
  logic [WIDTH-1:0] pat_q, pat_d;

  // Runtime pattern register, writable only while idle and not aborting
  always_comb begin
    pat_d = pat_q;
    if ((state_q == IDLE) && !abort && load) begin
      pat_d = pat_in;
    end else begin
      pat_d = pat_q;
    end
  end

  // Pattern register storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= SEQ;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign pattern_s = pat_q;
`else
  assign pattern_s = SEQ;
`endif

  seq_piso #(
    .WIDTH   (WIDTH),
    .RST_VAL (SEQ)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load_en  (piso_load_s),
    .shift_en (piso_shift_s),
    .par_in   ({1'b0, pattern_s[WIDTH-1:1]}),
    .bit0_o   (piso_bit0_s)
  );

  // FSM next state, counters and next registered outputs
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rep_d        = rep_q;
    gap_len_d    = gap_len_q;
    gap_cnt_d    = gap_cnt_q;
    out_d        = 1'b0;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    piso_load_s  = 1'b0;
    piso_shift_s = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = SEND;
            rep_d       = rep_cnt;
            gap_len_d   = gap;
            bit_cnt_d   = {CNT_W{1'b0}};
            piso_load_s = 1'b1;
            out_d       = pattern_s[0];
            valid_d     = 1'b1;
            busy_d      = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        SEND: begin
          busy_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (rep_q == {REP_W{1'b0}}) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_len_q != {GAP_W{1'b0}}) begin
              state_d   = GAP;
              rep_d     = rep_q - REP_W'(1);
              gap_cnt_d = gap_len_q;
            end else begin
              state_d     = SEND;
              rep_d       = rep_q - REP_W'(1);
              bit_cnt_d   = {CNT_W{1'b0}};
              piso_load_s = 1'b1;
              out_d       = pattern_s[0];
              valid_d     = 1'b1;
            end
          end else begin
            piso_shift_s = 1'b1;
            bit_cnt_d    = bit_cnt_q + CNT_W'(1);
            out_d        = piso_bit0_s;
            valid_d      = 1'b1;
          end
        end
        GAP: begin
          busy_d = 1'b1;
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d     = SEND;
            bit_cnt_d   = {CNT_W{1'b0}};
            piso_load_s = 1'b1;
            out_d       = pattern_s[0];
            valid_d     = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and output flops; reset clears all outputs at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= {CNT_W{1'b0}};
      rep_q     <= {REP_W{1'b0}};
      gap_len_q <= {GAP_W{1'b0}};
      gap_cnt_q <= {GAP_W{1'b0}};
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen with a loopback pattern matcher.
module tb_seq_gen;

  localparam logic [15:0] EXP_PAT = 16'hABCD;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  rep_cnt;
  logic [3:0]  gap;
  logic        load;
  logic [15:0] pat_in;
  logic        out_w;
  logic        valid_w;
  logic        busy_w;
  logic        done_w;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          cyc;
  int          busy_cnt;
  int          valid_cnt;
  int          gap_cyc;
  int          done_cnt;
  int          done_cyc;
  int          fires;
  int          fire1;
  int          fire2;
  logic [63:0] bits;
  logic [15:0] win;

  always #5 clk = ~clk;

  seq_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .rep_cnt (rep_cnt),
    .gap     (gap),
`ifdef SEQ_GEN_LOAD_EN
    .load    (load),
    .pat_in  (pat_in),
`endif
    .out     (out_w),
    .valid   (valid_w),
    .busy    (busy_w),
    .done    (done_w)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; busy_cnt = 0; valid_cnt = 0; gap_cyc = 0;
    done_cnt = 0; done_cyc = 0; fires = 0; fire1 = 0; fire2 = 0;
    bits = 64'd0; win = 16'd0;
  endtask

  // One clock: sample 1 time unit after the rising edge and log activity
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (busy_w) busy_cnt++;
    if (busy_w && !valid_w) gap_cyc++;
    if (valid_w) begin
      if (valid_cnt < 64) bits[valid_cnt] = out_w;
      valid_cnt++;
      win = {out_w, win[15:1]};
      if (win == EXP_PAT) begin
        fires++;
        if (fires == 1) fire1 = cyc + 1;
        else            fire2 = cyc + 1;
      end
    end
    if (done_w) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_w && n < 200) begin
      step();
      n++;
    end
    check_eq(tag, {63'd0, busy_w}, 64'd0);
  endtask

  task automatic kick(input logic [3:0] r, input logic [3:0] g);
    rep_cnt = r;
    gap     = g;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; load = 1'b0;
    rep_cnt = 4'd0; gap = 4'd0; pat_in = 16'd0;
    clear_mon();
    #12;
    check_eq("rst_out",   {63'd0, out_w},   64'd0);
    check_eq("rst_valid", {63'd0, valid_w}, 64'd0);
    check_eq("rst_busy",  {63'd0, busy_w},  64'd0);
    check_eq("rst_done",  {63'd0, done_w},  64'd0);
    step();
    rst = 1'b1;
    step();
    step();

    // Single frame
    clear_mon();
    kick(4'd0, 4'd0);
    check_eq("f1_first_busy",  {63'd0, busy_w},  64'd1);
    check_eq("f1_first_valid", {63'd0, valid_w}, 64'd1);
    check_eq("f1_first_out",   {63'd0, out_w},   64'd1);
    wait_idle("f1_timeout");
    check_eq("f1_bits",     {48'd0, bits[15:0]}, 64'hABCD);
    check_eq("f1_valid",    64'(valid_cnt), 64'd16);
    check_eq("f1_busy",     64'(busy_cnt),  64'd16);
    check_eq("f1_done_cnt", 64'(done_cnt),  64'd1);
    check_eq("f1_done_cyc", 64'(done_cyc),  64'd17);
    check_eq("f1_done_now", {63'd0, done_w}, 64'd1);
    check_eq("f1_fires",    64'(fires),     64'd1);
    check_eq("f1_fire_cyc", 64'(fire1),     64'd17);

    // Two back-to-back frames, started in the done cycle
    clear_mon();
    kick(4'd1, 4'd0);
    check_eq("f3_start_on_done", {63'd0, busy_w}, 64'd1);
    wait_idle("f3_timeout");
    check_eq("f3_valid",     64'(valid_cnt), 64'd32);
    check_eq("f3_busy",      64'(busy_cnt),  64'd32);
    check_eq("f3_bubbles",   64'(gap_cyc),   64'd0);
    check_eq("f3_bits",      {32'd0, bits[31:0]}, 64'hABCD_ABCD);
    check_eq("f3_fires",     64'(fires),     64'd2);
    check_eq("f3_fire_dist", 64'(fire2 - fire1), 64'd16);
    check_eq("f3_done_cnt",  64'(done_cnt),  64'd1);

    // Three frames with gap 3; rep/gap changes while busy ignored
    step();
    clear_mon();
    kick(4'd2, 4'd3);
    rep_cnt = 4'd0;
    gap     = 4'd0;
    wait_idle("f2_timeout");
    check_eq("f2_busy",     64'(busy_cnt),  64'd54);
    check_eq("f2_valid",    64'(valid_cnt), 64'd48);
    check_eq("f2_gap",      64'(gap_cyc),   64'd6);
    check_eq("f2_bits",     {16'd0, bits[47:0]}, {16'd0, 48'hABCD_ABCD_ABCD});
    check_eq("f2_done_cnt", 64'(done_cnt),  64'd1);
    check_eq("f2_done_cyc", 64'(done_cyc),  64'd55);
    check_eq("f2_fires",    64'(fires),     64'd3);

    // Start during a frame is ignored; abort at bit 9
    step();
    clear_mon();
    kick(4'd0, 4'd0);
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("ab_bit9_valid", {63'd0, valid_w}, 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("ab_busy",  {63'd0, busy_w},  64'd0);
    check_eq("ab_valid", {63'd0, valid_w}, 64'd0);
    check_eq("ab_out",   {63'd0, out_w},   64'd0);
    repeat (20) step();
    check_eq("ab_valid_cnt", 64'(valid_cnt), 64'd10);
    check_eq("ab_busy_cnt",  64'(busy_cnt),  64'd10);
    check_eq("ab_no_done",   64'(done_cnt),  64'd0);

    // Reset in the middle of a gap
    clear_mon();
    kick(4'd1, 4'd5);
    repeat (17) step();
    check_eq("rg_in_gap_busy",  {63'd0, busy_w},  64'd1);
    check_eq("rg_in_gap_valid", {63'd0, valid_w}, 64'd0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("rg_busy", {63'd0, busy_w},  64'd0);
    check_eq("rg_done", {63'd0, done_w},  64'd0);
    step();
    rst = 1'b1;
    step();
    clear_mon();
    kick(4'd0, 4'd0);
    wait_idle("rg_timeout");
    check_eq("rg_bits",  {48'd0, bits[15:0]}, 64'hABCD);
    check_eq("rg_valid", 64'(valid_cnt), 64'd16);
    check_eq("rg_done_cnt", 64'(done_cnt), 64'd1);

`ifdef SEQ_GEN_LOAD_EN
    // Runtime pattern load; load while busy must not disturb the frame
    step();
    load = 1'b1; pat_in = 16'h1234;
    step();
    load = 1'b0;
    clear_mon();
    kick(4'd0, 4'd0);
    repeat (3) step();
    load = 1'b1; pat_in = 16'hFFFF;
    step();
    load = 1'b0;
    wait_idle("ld_timeout");
    check_eq("ld_bits", {48'd0, bits[15:0]}, 64'h1234);
    step();
    clear_mon();
    kick(4'd0, 4'd0);
    wait_idle("ld2_timeout");
    check_eq("ld2_bits", {48'd0, bits[15:0]}, 64'h1234);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seq_gen
